load_store_unit: RTL

Bus initiator for the data memory: accepts load/store requests from the core's execute stage, sequences the word-wide data memory (synchronous write, combinational read), and returns sign/zero-extended load data. Sub-word stores use read-modify-write, since the data memory only writes full words. Sits between the core datapath and the memory wrapper's data port, under a valid/ready request and single-cycle response handshake.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I width codes and small funct3/address qualification functions.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths exist only for loads.
  function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  // True when the low address bits break natural alignment for the width.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Low address bits forced to natural alignment for the width.
  function automatic logic [1:0] lsu_align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word
// and merges sub-word store data into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_ld_word,
  input  logic [DATA_W-1:0] i_st_word,
  input  logic [1:0]        i_addr_lo,
  input  logic [2:0]        i_funct3,
  input  logic [15:0]       i_st_data,
  output logic [DATA_W-1:0] o_ld_data,
  output logic [DATA_W-1:0] o_st_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select for loads.
  always_comb begin
    w_byte = '0;
    case (i_addr_lo)
      2'd0: w_byte = i_ld_word[7:0];
      2'd1: w_byte = i_ld_word[15:8];
      2'd2: w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
  end

  // Sign/zero extension by width code.
  always_comb begin
    o_ld_data = i_ld_word;
    case (i_funct3)
      F3_B:    o_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
      F3_H:    o_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {{(DATA_W-16){1'b0}}, w_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    o_st_word = i_st_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0: o_st_word[7:0]   = i_st_data[7:0];
          2'd1: o_st_word[15:8]  = i_st_data[7:0];
          2'd2: o_st_word[23:16] = i_st_data[7:0];
          default: o_st_word[31:24] = i_st_data[7:0];
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) o_st_word[31:16] = i_st_data;
        else              o_st_word[15:0]  = i_st_data;
      end
      default: o_st_word = i_st_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready request in, single-cycle response pulse out,
// sequencing a word-wide data memory (sync write, comb read). Sub-word
// stores are read-modify-write.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/HU/W accesses return
// resp_err without touching memory; otherwise low address bits are aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t r_state, w_next;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_word;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic              w_accept;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_ld_data;
  logic [DATA_W-1:0] w_merged;

  assign w_accept = req_valid && (r_state == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign w_req_err  = !lsu_f3_legal(req_we, req_funct3) || lsu_misaligned(req_funct3, req_addr[1:0]);
  assign w_req_addr = req_addr;
`else
  assign w_req_err  = !lsu_f3_legal(req_we, req_funct3);
  assign w_req_addr = {req_addr[ADDR_W-1:2], lsu_align_lo(req_funct3, req_addr[1:0])};
`endif

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .i_ld_word (r_word),
    .i_st_word (mem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .i_st_data (r_wdata),
    .o_ld_data (w_ld_data),
    .o_st_word (w_merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)                w_next = RESP;
          else if (!req_we)             w_next = READ;
          else if (req_funct3 == F3_W)  w_next = WRITE;
          else                          w_next = READ;
        end
      end
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, memory-side registers and response registers.
  // The response is registered on the edge leaving RESP, so it appears
  // in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_word       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= w_req_addr;
        r_wdata  <= req_wdata[15:0];
        r_err    <= w_req_err;
      end
      if (r_state == READ) r_word <= mem_rdata;

      r_mem_we <= (w_next == WRITE);
      if (r_state == IDLE && w_next == WRITE)      r_mem_wdata <= req_wdata;
      else if (r_state == READ && w_next == WRITE) r_mem_wdata <= w_merged;

      if (r_state == RESP) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= r_err;
        r_resp_rdata <= (r_we || r_err) ? '0 : w_ld_data;
      end else begin
        r_resp_valid <= 1'b0;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign mem_we     = r_mem_we;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule
